dmem_bridge: RTL
================

# dmem_bridge

Bridge between the pipeline's MEM stage and a multi-cycle word-addressed data bus with a req/ack handshake. It registers the MEM-stage access (read or write) and holds the pipeline through `mem_stall` until the bus completes. It then presents the read data on `mem_din` until the pipeline advances past MEM. Misaligned accesses, bus errors and bus timeouts are reported without hanging the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles in REQ awaiting `bus_ack` before a forced timeout; range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `cpu_rst_n`  in  1  asynchronous, active-low reset.
- `mem_ren`  in  1  MEM-stage read enable.
- `mem_wen`  in  1  MEM-stage write enable.
- `mem_addr`  in  32  MEM-stage byte address (ALU result).
- `mem_dout`  in  32  MEM-stage store data.
- `mem_advance`  in  1  pipeline latches MEM→WB this cycle (the WB-stage enable).
- `mem_din`  out  32  load data to the datapath.
- `mem_stall`  out  1  freeze IF/ID/EXE/MEM registers.
- `mem_err`  out  1  current access completed with a fault.
- `mem_err_code`  out  2  0 none, 1 misaligned, 2 timeout, 3 bus error.
- `bus_req`  out  1  bus request; held until ack.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata`  out  32  store data.
- `bus_ack`  in  1  one-cycle completion strobe.
- `bus_err`  in  1  sampled with `bus_ack`; marks a faulted transfer.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.

## Operation
- Access present: `acc = mem_ren | mem_wen`. If both are high, the access is a write.
- FSM states: IDLE, REQ, DONE.
- IDLE, `acc=0`: stay in IDLE; `mem_stall=0`.
- IDLE, `acc=1`, `mem_addr[1:0]==0`:
  - capture `{we, addr, dout}` and go to REQ;
  - clear the timeout counter;
  - `mem_stall=1` (combinational, this cycle).
- IDLE, `acc=1`, `mem_addr[1:0]!=0`:
  - go to DONE with code 1 and no bus access;
  - `mem_stall=1` this cycle.
- REQ: `bus_req=1`, and `bus_we/bus_addr/bus_wdata` come from the captured values. `mem_*` inputs are ignored, and `mem_stall=1`.
  - `bus_ack & !bus_err`: go to DONE with code 0. On a read, capture `bus_rdata` into the data register.
  - `bus_ack & bus_err`: go to DONE with code 3; data register = 0.
  - No ack and counter == `TIMEOUT_CYCLES-1`: go to DONE with code 2; data register = 0. Otherwise increment the counter (8-bit, saturating).
- DONE:
  - `mem_stall=0`;
  - `mem_din` = data register (0 after a write);
  - `mem_err = (code!=0)`.
  - If `mem_advance=1` or `acc=0` (stage flushed), go to IDLE. Otherwise hold DONE; the held access is never reissued.
- Outside DONE: `mem_din=0`, `mem_err=0`, `mem_err_code=0`.
- `bus_req=0` in IDLE and DONE; `bus_we/bus_addr/bus_wdata` = 0 when `bus_req=0`.
- A late `bus_ack` arriving outside REQ is ignored.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; counter 0; captured regs 0.
  - Outputs: `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `mem_din=0`, `mem_err=0`, `mem_err_code=0`.
  - `mem_stall=0` only while `acc=0`.
- Reset asserted mid-REQ drops `bus_req` immediately. The outstanding transfer is abandoned.
- Aligned access with ack in bus cycle k (the first REQ cycle is k=1): `mem_stall` high for k+1 cycles, DONE in cycle k+1 (cycle 0 = IDLE detection).
- Minimum load-use cost: 2 stall cycles (ack in the first REQ cycle).
- Misaligned access: exactly 1 stall cycle.
- Timeout: REQ lasts exactly `TIMEOUT_CYCLES` cycles, then DONE.
- Back-to-back accesses: DONE→IDLE on advance. The next access is detected in the following cycle (IDLE), so every access costs at least one IDLE cycle.
- `bus_req` is a registered state decode and glitch-free. `mem_stall` is combinational from state and `acc`.

## Test plan
- Load: `mem_ren=1`, `addr=0x0000_0010`; bus acks on the 1st REQ cycle with `rdata=0x1234_5678`.
  - Required: stall for 2 cycles, then `mem_din=0x1234_5678` with `mem_err=0`.
  - `bus_addr=0x10`, `bus_we=0`.
- Store: `mem_wen=1`, `addr=0x20`, `dout=0xCAFE_F00D`; ack after 3 REQ cycles.
  - Required: `bus_we=1`, `bus_wdata=0xCAFE_F00D` held for all 3 cycles, 4 stall cycles.
  - `mem_din=0` in DONE.
- Misaligned: `mem_ren=1`, `addr=0x13`.
  - Required: no `bus_req`, 1 stall cycle, DONE with `mem_err=1`, `mem_err_code=1`.
- Timeout: `TIMEOUT_CYCLES=4`, no ack.
  - Required: `bus_req` high exactly 4 cycles, then `mem_err_code=2`, `mem_din=0`.
  - A later ack is ignored.
- Held DONE and reset:
  - Hold `mem_advance=0` for 3 cycles after a load completes. Required: `mem_din` stable and no second `bus_req`; IDLE after `mem_advance=1`.
  - Then issue a load and pull `cpu_rst_n` low mid-REQ. Required: `bus_req` drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/dmem_bridge.sv
// MEM-stage to word bus bridge: one outstanding access, stalls the
// pipeline until ack, error or timeout, then holds the result for WB.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        cpu_rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        mem_advance,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  mem_err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [1:0]  code_q;

  logic acc;
  logic in_req;
  logic in_done;

  assign acc     = mem_ren | mem_wen;
  assign in_req  = (state_q == REQ);
  assign in_done = (state_q == DONE);

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      code_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            if (mem_addr[1:0] == 2'b00) begin
              state_q <= REQ;
              we_q    <= mem_wen;
              addr_q  <= {mem_addr[31:2], 2'b00};
              wdata_q <= mem_dout;
              cnt_q   <= '0;
            end else begin
              state_q <= DONE;
              code_q  <= 2'd1;
              data_q  <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state_q <= DONE;
            code_q  <= bus_err ? 2'd3 : 2'd0;
            data_q  <= (bus_err || we_q) ? '0 : bus_rdata;
          end else if (cnt_q == CntLast) begin
            state_q <= DONE;
            code_q  <= 2'd2;
            data_q  <= '0;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          // a held access is never reissued; only advance or flush leaves
          if (mem_advance || !acc) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall    = in_req | ((state_q == IDLE) & acc);
  assign mem_din      = in_done ? data_q : '0;
  assign mem_err      = in_done & (code_q != 2'd0);
  assign mem_err_code = in_done ? code_q : 2'd0;

  assign bus_req   = in_req;
  assign bus_we    = in_req & we_q;
  assign bus_addr  = in_req ? addr_q : '0;
  assign bus_wdata = in_req ? wdata_q : '0;

endmodule
